mealy_fsm_seq_ctrl: RTL and testbench
=====================================

// Module: mealy_fsm_seq_ctrl
// PURPOSE
//  Sequencer that exercises the Mealy FSM datapath (inputs A/B/I, outputs Qa/Qb/Y) in-system.
//  Steps a host-loaded table of {A,B,I} vectors into the FSM and checks {Qa,Qb,Y} against expected values.
//  Reports an error count and the first failing step; sits between the host/config logic and the FSM.
// PARAMETERS
//  DEPTH  8  table entries (steps); power of two
//  PTR_W  3  log2(DEPTH); width of step index
// PORTS
//  CLK        in   1        system clock, rising edge
//  RST        in   1        asynchronous, active-high reset
//  LD_EN      in   1        write table entry LD_ADDR this cycle (ignored while BUSY)
//  LD_ADDR    in   PTR_W    table write index
//  LD_VEC     in   3        stimulus {A,B,I}
//  LD_EXP     in   3        expected {Qa,Qb,Y}
//  LEN        in   PTR_W+1  steps to run; sampled on START; values >DEPTH are clamped to DEPTH
//  START      in   1        begin run (accepted only in IDLE or DONE)
//  ABORT      in   1        synchronous abort to IDLE; wins over all other inputs except RST
//  A, B, I    out  1 each   registered drive to FSM inputs
//  QA_IN, QB_IN, Y_IN  in  1 each  FSM outputs
//  BUSY       out  1        high in DRIVE/SAMPLE
//  DONE       out  1        high in DONE state (level)
//  ERR_CNT    out  PTR_W+1  mismatching steps this run
//  FAIL_VALID out  1        at least one mismatch this run
//  FAIL_STEP  out  PTR_W    index of first mismatching step (valid when FAIL_VALID)
// BEHAVIOUR
//  Reset: state=IDLE; A=B=I=0; BUSY=DONE=FAIL_VALID=0; ERR_CNT=0; FAIL_STEP=0; table cleared to 0.
//  States: IDLE, DRIVE, SAMPLE, DONE.
//  - IDLE/DONE + START: latch n=min(LEN,DEPTH), step k=0, clear ERR_CNT/FAIL_VALID/FAIL_STEP, DONE=0.
//    - If n=0, go directly to DONE.
//    - Otherwise go to DRIVE.
//  - DRIVE (1 cycle): {A,B,I} <= table_vec[k] at the entry edge; go to SAMPLE.
//  - SAMPLE (1 cycle): {A,B,I} held; FSM state updates on the edge ending DRIVE.
//    - At the edge ending SAMPLE, compare {QA_IN,QB_IN,Y_IN} against table_exp[k].
//    - On mismatch: ERR_CNT+1; if FAIL_VALID=0, set FAIL_VALID=1 and FAIL_STEP=k.
//    - If k==n-1, go to DONE; otherwise k++ and go to DRIVE.
//  - DONE: A=B=I hold their last values; results hold until the next START or RST.
//  Latency: 2 cycles per step; n-step run reaches DONE 2n cycles after the START edge.
//  Widths: ERR_CNT max = DEPTH, fits PTR_W+1 bits, no wrap. The k compare uses PTR_W+1 bits so n=DEPTH works.
//  Simultaneous events:
//    - START while BUSY is ignored.
//    - LD_EN while BUSY is ignored, so the table is stable during a run.
//    - LD_EN together with START in IDLE: the write takes effect; the run reads the table from the next cycle on.
//    - ABORT: next state IDLE; A=B=I=0; BUSY=DONE=0; ERR_CNT/FAIL_* keep partial values.
//  RST mid-run: immediate return to reset values; the in-flight step is discarded.
// TESTING
//  1 Load 6 vectors 000,001,010,011,100,101 with the correct FSM expected values; LEN=6; START.
//    -> BUSY for 12 cycles, then DONE=1, ERR_CNT=0, FAIL_VALID=0.
//  2 Same table with exp[2] and exp[4] corrupted (Y bit flipped).
//    -> ERR_CNT=2, FAIL_VALID=1, FAIL_STEP=2.
//  3 LEN=0 + START -> DONE=1 on the next cycle, BUSY never asserted, A/B/I unchanged.
//  4 LEN=15 (>DEPTH) -> runs 8 steps; DONE exactly 16 cycles after START.
//  5 START and LD_EN to addr 0 pulsed at step 3 of a run -> both ignored; results match the original table.
//  6 RST asserted mid-SAMPLE -> outputs zero asynchronously; ABORT at step 2 -> IDLE, ERR_CNT holds its partial value.

Source files
------------

// File: rtl/mealy_fsm_seq_ctrl.sv
// In-system sequencer for the Mealy FSM datapath: steps a host-loaded {A,B,I} table
// into the FSM, checks {Qa,Qb,Y} against expected values and reports errors.
module mealy_fsm_seq_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_en,
    input  logic [PTR_W-1:0] ld_addr,
    input  logic [2:0]       ld_vec,
    input  logic [2:0]       ld_exp,
    input  logic [PTR_W:0]   len,
    input  logic             start,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             i,
    input  logic             qa_in,
    input  logic             qb_in,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic [PTR_W:0]   err_cnt,
    output logic             fail_valid,
    output logic [PTR_W-1:0] fail_step
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       tbl_vec_q [DEPTH];
    logic [2:0]       tbl_exp_q [DEPTH];
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [2:0]       drv_q, drv_d;
    logic             busy_d, done_d, fail_valid_d;
    logic [CNT_W-1:0] err_cnt_d;
    logic [PTR_W-1:0] fail_step_d;

    logic             idle_or_done_c;
    logic             wr_en_c;
    logic [CNT_W-1:0] len_clamped_c;
    logic [2:0]       first_vec_c;

    assign idle_or_done_c = (state_q == S_IDLE) || (state_q == S_DONE);
    assign wr_en_c        = ld_en && !abort && idle_or_done_c;
    assign len_clamped_c  = (len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len;
    // A write to entry 0 on the START edge is forwarded so the run sees the new vector.
    assign first_vec_c    = (wr_en_c && (ld_addr == PTR_W'(0))) ? ld_vec : tbl_vec_q[PTR_W'(0)];

    // Stimulus/expected table
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                tbl_vec_q[j] <= 3'b000;
                tbl_exp_q[j] <= 3'b000;
            end
        end else if (wr_en_c) begin
            tbl_vec_q[ld_addr] <= ld_vec;
            tbl_exp_q[ld_addr] <= ld_exp;
        end
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            k_q        <= '0;
            drv_q      <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_step  <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            drv_q      <= drv_d;
            busy       <= busy_d;
            done       <= done_d;
            err_cnt    <= err_cnt_d;
            fail_valid <= fail_valid_d;
            fail_step  <= fail_step_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        k_d          = k_q;
        drv_d        = drv_q;
        busy_d       = busy;
        done_d       = done;
        err_cnt_d    = err_cnt;
        fail_valid_d = fail_valid;
        fail_step_d  = fail_step;

        if (abort) begin
            state_d = S_IDLE;
            drv_d   = 3'b000;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n_d          = len_clamped_c;
                        k_d          = '0;
                        err_cnt_d    = '0;
                        fail_valid_d = 1'b0;
                        fail_step_d  = '0;
                        if (len_clamped_c == '0) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DRIVE;
                            busy_d  = 1'b1;
                            done_d  = 1'b0;
                            drv_d   = first_vec_c;
                        end
                    end
                end
                S_DRIVE: begin
                    state_d = S_SAMPLE;
                end
                S_SAMPLE: begin
                    if ({qa_in, qb_in, y_in} != tbl_exp_q[k_q[PTR_W-1:0]]) begin
                        err_cnt_d = err_cnt + CNT_W'(1);
                        if (!fail_valid) begin
                            fail_valid_d = 1'b1;
                            fail_step_d  = k_q[PTR_W-1:0];
                        end
                    end
                    if (k_q == n_q - CNT_W'(1)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        k_d     = k_q + CNT_W'(1);
                        state_d = S_DRIVE;
                        drv_d   = tbl_vec_q[k_d[PTR_W-1:0]];
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign a = drv_q[2];
    assign b = drv_q[1];
    assign i = drv_q[0];

endmodule

// File: tb/tb_mealy_fsm_seq_ctrl.sv
// Self-checking bench for mealy_fsm_seq_ctrl: a small Mealy plant closes the loop and a
// table-level scoreboard predicts error count, first failing step and run length.
module tb_mealy_fsm_seq_ctrl;

    logic       clk, rst;
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [2:0] ld_vec, ld_exp;
    logic [3:0] len;
    logic       start, abort;
    logic       a, b, i;
    logic       qa_in, qb_in, y_in;
    logic       busy, done;
    logic [3:0] err_cnt;
    logic       fail_valid;
    logic [2:0] fail_step;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] m_vec [8];
    logic [2:0] m_exp [8];

    mealy_fsm_seq_ctrl #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_vec(ld_vec),
        .ld_exp(ld_exp), .len(len), .start(start), .abort(abort),
        .a(a), .b(b), .i(i), .qa_in(qa_in), .qb_in(qb_in), .y_in(y_in),
        .busy(busy), .done(done), .err_cnt(err_cnt), .fail_valid(fail_valid),
        .fail_step(fail_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plant: Qa' = A^I, Qb' = B|(A&I), Y = Qa ^ (Qb & I)
    logic pqa, pqb;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pqa <= 1'b0;
            pqb <= 1'b0;
        end else begin
            pqa <= a ^ i;
            pqb <= b | (a & i);
        end
    end
    assign qa_in = pqa;
    assign qb_in = pqb;
    assign y_in  = pqa ^ (pqb & i);

    // Plant response observed while vector v is held for two cycles
    function automatic logic [2:0] exp_of(input logic [2:0] v);
        logic qa, qb;
        qa = v[2] ^ v[0];
        qb = v[1] | (v[2] & v[0]);
        return {qa, qb, qa ^ (qb & v[0])};
    endfunction

    task automatic model_run(input int n, output int e, output logic fv, output int fs);
        e = 0; fv = 1'b0; fs = 0;
        for (int k = 0; k < n; k++) begin
            if (exp_of(m_vec[k]) != m_exp[k]) begin
                e++;
                if (!fv) begin fv = 1'b1; fs = k; end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin m_vec[k] = 3'b000; m_exp[k] = 3'b000; end
    endtask

    task automatic load(input int addr, input logic [2:0] v, input logic [2:0] e);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 3'(addr); ld_vec = v; ld_exp = e;
        @(negedge clk);
        ld_en = 1'b0;
        m_vec[addr] = v; m_exp[addr] = e;
    endtask

    // Pulse START, then count cycles until DONE (bounded) and cycles with BUSY high
    task automatic run_len(input logic [3:0] l, output int cyc, output int bcyc);
        @(negedge clk);
        len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; bcyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) bcyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({a, b, i} !== 3'b000) $display("FAIL reset_abi: got %b want 000", {a, b, i}); else n_pass++;
        n_checks++;
        if ({busy, done, fail_valid} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, fail_valid}); else n_pass++;
        n_checks++;
        if (err_cnt !== 4'd0 || fail_step !== 3'd0) $display("FAIL reset_results: got err=%0d step=%0d want 0/0", err_cnt, fail_step); else n_pass++;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin m_vec[k] = 3'b000; m_exp[k] = 3'b000; end
    endtask

    task automatic test_cleared_table();
        int cyc, bcyc;
        run_len(4'd8, cyc, bcyc);
        n_checks++;
        if (cyc !== 16 || err_cnt !== 4'd0) $display("FAIL cleared_table: got cyc=%0d err=%0d want 16/0", cyc, err_cnt); else n_pass++;
    endtask

    task automatic test_pass();
        int cyc, bcyc;
        for (int k = 0; k < 6; k++) load(k, 3'(k), exp_of(3'(k)));
        run_len(4'd6, cyc, bcyc);
        n_checks++;
        if (cyc !== 12 || bcyc !== 12) $display("FAIL pass_timing: got cyc=%0d busy=%0d want 12/12", cyc, bcyc); else n_pass++;
        n_checks++;
        if (done !== 1'b1 || err_cnt !== 4'd0 || fail_valid !== 1'b0) $display("FAIL pass_result: got done=%b err=%0d fv=%b want 1/0/0", done, err_cnt, fail_valid); else n_pass++;
        n_checks++;
        if ({a, b, i} !== 3'b101) $display("FAIL pass_abi_hold: got %b want 101", {a, b, i}); else n_pass++;
    endtask

    task automatic test_corrupt();
        int cyc, bcyc;
        load(2, m_vec[2], m_exp[2] ^ 3'b001);
        load(4, m_vec[4], m_exp[4] ^ 3'b001);
        run_len(4'd6, cyc, bcyc);
        n_checks++;
        if (err_cnt !== 4'd2 || fail_valid !== 1'b1 || fail_step !== 3'd2)
            $display("FAIL corrupt: got err=%0d fv=%b step=%0d want 2/1/2", err_cnt, fail_valid, fail_step);
        else n_pass++;
    endtask

    task automatic test_len_zero();
        int cyc, bcyc;
        logic [2:0] held;
        held = {a, b, i};
        run_len(4'd0, cyc, bcyc);
        n_checks++;
        if (cyc !== 0 || bcyc !== 0 || done !== 1'b1) $display("FAIL len_zero: got cyc=%0d busy=%0d done=%b want 0/0/1", cyc, bcyc, done); else n_pass++;
        n_checks++;
        if ({a, b, i} !== held || err_cnt !== 4'd0) $display("FAIL len_zero_hold: got abi=%b err=%0d want %b/0", {a, b, i}, err_cnt, held); else n_pass++;
    endtask

    task automatic test_len_clamp();
        int cyc, bcyc, e, fs;
        logic fv;
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'($urandom_range(0, 7));
            load(k, v, ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : exp_of(v));
        end
        model_run(8, e, fv, fs);
        run_len(4'd15, cyc, bcyc);
        n_checks++;
        if (cyc !== 16 || bcyc !== 16) $display("FAIL clamp_timing: got cyc=%0d busy=%0d want 16/16", cyc, bcyc); else n_pass++;
        n_checks++;
        if (err_cnt !== 4'(e) || fail_valid !== fv || fail_step !== 3'(fs))
            $display("FAIL clamp_result: got err=%0d fv=%b step=%0d want %0d/%b/%0d", err_cnt, fail_valid, fail_step, e, fv, fs);
        else n_pass++;
    endtask

    task automatic test_ignore_busy();
        int cyc, e, fs;
        logic fv;
        model_run(8, e, fv, fs);
        @(negedge clk);
        len = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        // in DRIVE of step 3: pulse both START and a write to entry 0
        start = 1'b1; ld_en = 1'b1; ld_addr = 3'd0; ld_vec = ~m_vec[0]; ld_exp = ~m_exp[0];
        @(negedge clk);
        start = 1'b0; ld_en = 1'b0;
        cyc = 7;
        while (done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        n_checks++;
        if (cyc !== 16) $display("FAIL busy_ignore_timing: got %0d want 16", cyc); else n_pass++;
        n_checks++;
        if (err_cnt !== 4'(e) || fail_valid !== fv || fail_step !== 3'(fs))
            $display("FAIL busy_ignore_result: got err=%0d fv=%b step=%0d want %0d/%b/%0d", err_cnt, fail_valid, fail_step, e, fv, fs);
        else n_pass++;
        n_checks++;
        if (dut.tbl_vec_q[0] !== m_vec[0] || dut.tbl_exp_q[0] !== m_exp[0])
            $display("FAIL busy_ignore_table: got %b/%b want %b/%b", dut.tbl_vec_q[0], dut.tbl_exp_q[0], m_vec[0], m_exp[0]);
        else n_pass++;
    endtask

    task automatic test_rst_abort();
        @(negedge clk);
        len = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        // mid-SAMPLE of step 1: asynchronous reset between edges
        rst = 1'b1;
        #1;
        n_checks++;
        if ({a, b, i, busy, done, fail_valid} !== 6'b0 || err_cnt !== 4'd0)
            $display("FAIL rst_async: got abi=%b busy=%b done=%b fv=%b err=%0d want all 0", {a, b, i}, busy, done, fail_valid, err_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin m_vec[k] = 3'b000; m_exp[k] = 3'b000; end
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'($urandom_range(0, 7));
            load(k, v, (k < 2) ? (exp_of(v) ^ 3'b010) : exp_of(v));
        end
        @(negedge clk);
        len = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({a, b, i, busy, done} !== 5'b0) $display("FAIL abort_state: got abi=%b busy=%b done=%b want 0", {a, b, i}, busy, done); else n_pass++;
        n_checks++;
        if (err_cnt !== 4'd2 || fail_valid !== 1'b1 || fail_step !== 3'd0)
            $display("FAIL abort_partial: got err=%0d fv=%b step=%0d want 2/1/0", err_cnt, fail_valid, fail_step);
        else n_pass++;
    endtask

    task automatic test_random();
        int cyc, bcyc, e, fs, n;
        logic fv;
        logic [3:0] l;
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(1, 4)) begin
                logic [2:0] v;
                int ad;
                v  = 3'($urandom_range(0, 7));
                ad = $urandom_range(0, 7);
                load(ad, v, ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 7)) : exp_of(v));
            end
            l = 4'($urandom_range(0, 15));
            n = (l > 4'd8) ? 8 : int'(l);
            model_run(n, e, fv, fs);
            run_len(l, cyc, bcyc);
            n_checks++;
            if (cyc !== 2 * n || bcyc !== 2 * n)
                $display("FAIL rand_timing[%0d]: got cyc=%0d busy=%0d want %0d", r, cyc, bcyc, 2 * n);
            else n_pass++;
            n_checks++;
            if (err_cnt !== 4'(e) || fail_valid !== fv || fail_step !== 3'(fs))
                $display("FAIL rand_result[%0d]: got err=%0d fv=%b step=%0d want %0d/%b/%0d", r, err_cnt, fail_valid, fail_step, e, fv, fs);
            else n_pass++;
            if (n > 0) begin
                n_checks++;
                if ({a, b, i} !== m_vec[n-1]) $display("FAIL rand_abi[%0d]: got %b want %b", r, {a, b, i}, m_vec[n-1]); else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; ld_en = 1'b0; ld_addr = 3'd0; ld_vec = 3'd0; ld_exp = 3'd0;
        len = 4'd0; start = 1'b0; abort = 1'b0;
        test_reset();
        test_cleared_table();
        test_pass();
        test_corrupt();
        test_len_zero();
        test_len_clamp();
        test_ignore_busy();
        test_rst_abort();
        do_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
